// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - Mastermind shared constants: button indices and repeat-FSM states.
package mm_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_S = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: synchronizer, debounce, press pulse.
// Hold-to-repeat FSM is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
  import mm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic          settle;
  logic          rise;

  // settle marks the edge on which the level flips; the FSM reacts on that same edge
  assign settle = (sync2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle && !level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (settle) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  rpt_state_e    state;
  logic [RW-1:0] rpt_cnt;
  logic          fall;

  assign fall = settle && level;

  // a release that settles on a terminal-count edge wins, so no pulse follows release
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (fall) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            rpt_cnt <= '0;
            if (rise) begin
              pulse <= 1'b1;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
              pulse   <= 1'b1;
              state   <= REPEAT;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt == RW'(REPEAT_RATE - 1)) begin
              pulse   <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= rise;
    end
  end
`endif

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five-button front end producing debounced levels and press pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on every channel.
module btn_conditioner #(
  parameter int NUM_BTNS        = mm_pkg::NUM_BTNS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic [NUM_BTNS-1:0] btn_level
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .pulse(btn_pulse[i]),
      .level(btn_level[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench for btn_conditioner (DEBOUNCE=4, DELAY=10, RATE=3).
// Expectations follow BTN_AUTOREPEAT_EN the same way the design does.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTNS       (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // press on edge 0, held: pulse after edge 5, then repeats at 15, 18, 21, ...
  function automatic bit exp_rep(input int e);
    if (e == 5) return 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    if (e >= 15 && ((e - 15) % 3) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // release everything; prev is the level before release, rp/rmask an expected in-flight pulse
  task automatic release_all(input string tag, input logic [4:0] prev, input int rp, input logic [4:0] rmask);
    btn_raw = '0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("%s_rel_pulse_e%0d", tag, e), btn_pulse, (e == rp) ? rmask : 5'b0);
      check($sformatf("%s_rel_level_e%0d", tag, e), btn_level, (e >= 5) ? 5'b0 : prev);
    end
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    btn_raw = 5'b11111;
    tick();
    tick();
    check("reset_pulse", btn_pulse, 5'b0);
    check("reset_level", btn_level, 5'b0);
    btn_raw = '0;
    rst = 1'b0;
    for (int e = 0; e < 6; e++) tick();

    // clean press on U
    btn_raw = 5'b01000;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("clean_pulse_e%0d", e), btn_pulse, (e == 5) ? 5'b01000 : 5'b0);
      check($sformatf("clean_level_e%0d", e), btn_level, (e >= 5) ? 5'b01000 : 5'b0);
    end
    release_all("clean", 5'b01000, -1, 5'b0);

    // bounce: 2 high / 2 low for 12 cycles, final rise at edge 12
    for (int e = 0; e < 20; e++) begin
      btn_raw = (e >= 12 || ((e / 2) % 2) == 0) ? 5'b01000 : 5'b0;
      tick();
      check($sformatf("bounce_pulse_e%0d", e), btn_pulse, (e == 17) ? 5'b01000 : 5'b0);
      check($sformatf("bounce_level_e%0d", e), btn_level, (e >= 17) ? 5'b01000 : 5'b0);
    end
    release_all("bounce", 5'b01000, -1, 5'b0);

    // auto-repeat: U held 40 cycles
    btn_raw = 5'b01000;
    for (int e = 0; e < 40; e++) begin
      tick();
      check($sformatf("rep_pulse_e%0d", e), btn_pulse, exp_rep(e) ? 5'b01000 : 5'b0);
    end
`ifdef BTN_AUTOREPEAT_EN
    release_all("rep", 5'b01000, 2, 5'b01000);
`else
    release_all("rep", 5'b01000, -1, 5'b0);
`endif

    // simultaneous press of R and U
    btn_raw = 5'b01010;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("simul_pulse_e%0d", e), btn_pulse, (e == 5) ? 5'b01010 : 5'b0);
      check($sformatf("simul_level_e%0d", e), btn_level, (e == 5) ? 5'b01010 : 5'b0);
    end
    // release R and U while pressing L in the same cycle
    btn_raw = 5'b00100;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("swap_pulse_e%0d", e), btn_pulse, (e == 5) ? 5'b00100 : 5'b0);
      check($sformatf("swap_level_e%0d", e), btn_level, (e == 5) ? 5'b00100 : 5'b01010);
    end
    release_all("swap", 5'b00100, -1, 5'b0);

    // reset on the edge where a REPEAT terminal count would fire
    btn_raw = 5'b01000;
    for (int e = 0; e < 21; e++) begin
      tick();
      check($sformatf("prerst_pulse_e%0d", e), btn_pulse, exp_rep(e) ? 5'b01000 : 5'b0);
    end
    rst = 1'b1;
    tick();
    check("midrst_pulse", btn_pulse, 5'b0);
    check("midrst_level", btn_level, 5'b0);
    rst = 1'b0;

    // held through reset: new press, then a 2-cycle release glitch at edges 20-21
    for (int e = 0; e < 36; e++) begin
      btn_raw = (e == 20 || e == 21) ? 5'b0 : 5'b01000;
      tick();
      check($sformatf("glitch_pulse_e%0d", e), btn_pulse, exp_rep(e) ? 5'b01000 : 5'b0);
      check($sformatf("glitch_level_e%0d", e), btn_level, (e >= 5) ? 5'b01000 : 5'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
